// File: rtl/instr_fetch_pkg.sv
// Shared fetch/decode constants and the buffered-instruction record type.
package instr_fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_fifo.sv
// Small instruction buffer between the memory response path and decode.
// Head is readable combinationally so decode sees it in the cycle it lands.
module fetch_fifo
  import instr_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  fetch_entry_t             wdata,
  output fetch_entry_t             rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  fetch_entry_t   mem [DEPTH];
  logic [AW-1:0]  wr_ptr_reg;
  logic [AW-1:0]  rd_ptr_reg;
  logic [AW:0]    count_reg;
  logic           do_push;
  logic           do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign count   = count_reg;
  assign rdata   = mem[rd_ptr_reg];

  // Flush wins over both push and pop; a push into a full buffer is only
  // legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty & ~flush;
  assign do_push = push & ~flush & (~full | do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_reg + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: single-outstanding request FSM, fetch PC, and drop
// tracking for responses orphaned by a redirect.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = DEFAULT_RESET_PC,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_rstn,
  output logic        o_IM_Req,
  output logic [31:0] o_IM_Addr,
  input  logic        i_IM_Gnt,
  input  logic        i_IM_RValid,
  input  logic [31:0] i_IM_RData,
  input  logic        i_Redirect,
  input  logic [31:0] i_Redirect_PC,
  input  logic        i_Stall,
  output logic        o_Valid,
  output logic [31:0] o_Instr,
  output logic [31:0] o_PC
);

  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] WAIT_RSP = 1'b1;
  localparam int         CW       = $clog2(FIFO_DEPTH) + 1;

  logic [0:0]   state_reg;
  logic         drop_reg;
  logic [31:0]  pc_reg;
  logic [31:0]  tag_pc_reg;

  logic         grant;
  logic         rsp;
  logic         fifo_push;
  logic         fifo_pop;
  logic         fifo_empty;
  logic         fifo_full;
  logic [CW-1:0] fifo_count;
  logic [31:0]  redirect_target;
  fetch_entry_t fifo_wdata;
  fetch_entry_t fifo_head;

  assign redirect_target = i_Redirect_PC & ~32'h0000_0003;

  // Request is gated by reset so the port reads idle while held in reset.
  assign o_IM_Req  = i_rstn & ~i_Redirect & (state_reg == IDLE)
                   & (fifo_count < CW'(FIFO_DEPTH));
  assign o_IM_Addr = pc_reg;
  assign grant     = o_IM_Req & i_IM_Gnt;
  assign rsp       = i_IM_RValid & (state_reg == WAIT_RSP);

  assign fifo_push  = rsp & ~drop_reg & ~i_Redirect & ~fifo_full;
  assign fifo_wdata = '{pc: tag_pc_reg, instr: i_IM_RData};

  assign o_Valid  = ~fifo_empty & ~i_Redirect;
  assign fifo_pop = o_Valid & ~i_Stall;
  assign o_Instr  = o_Valid ? fifo_head.instr : NOP_INSTR;
  assign o_PC     = o_Valid ? fifo_head.pc    : 32'h0000_0000;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_reg  <= IDLE;
      drop_reg   <= 1'b0;
      pc_reg     <= {RESET_PC[31:2], 2'b00};
      tag_pc_reg <= {RESET_PC[31:2], 2'b00};
    end else if (i_Redirect) begin
      pc_reg <= redirect_target;
      // An in-flight request either answers now (discarded here) or later (dropped).
      if (state_reg == WAIT_RSP) begin
        if (i_IM_RValid) begin
          state_reg <= IDLE;
          drop_reg  <= 1'b0;
        end else begin
          drop_reg  <= 1'b1;
        end
      end
    end else if (grant) begin
      state_reg  <= WAIT_RSP;
      tag_pc_reg <= pc_reg;
      pc_reg     <= pc_reg + 32'd4;
    end else if (rsp) begin
      state_reg <= IDLE;
      drop_reg  <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst_n (i_rstn),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .flush (i_Redirect),
    .wdata (fifo_wdata),
    .rdata (fifo_head),
    .empty (fifo_empty),
    .full  (fifo_full),
    .count (fifo_count)
  );

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 Parameter FIFO_DEPTH, default 2, instruction buffer entries; power of two, at least 2.
REQ-003 i_clk  in  1  single clock; all state on rising edge.
REQ-004 i_rstn  in  1  asynchronous, active-low reset.
REQ-005 o_IM_Req  out  1  instruction-memory request valid.
REQ-006 o_IM_Addr  out  32  request address; bits [1:0] always 0.
REQ-007 i_IM_Gnt  in  1  request accepted in a cycle where o_IM_Req=1.
REQ-008 i_IM_RValid  in  1  response data valid; response for the oldest accepted request.
REQ-009 i_IM_RData  in  32  response instruction word.
REQ-010 i_Redirect  in  1  pipeline redirect (branch, jump or trap).
REQ-011 i_Redirect_PC  in  32  redirect target; bits [1:0] ignored.
REQ-012 i_Stall  in  1  decode stall; same signal as the decoder's stall input.
REQ-013 o_Valid  out  1  o_Instr and o_PC hold a real instruction.
REQ-014 o_Instr  out  32  instruction to decode/main control.
REQ-015 o_PC  out  32  address of o_Instr.

Function
REQ-016 Internal state: fetch PC register, outstanding counter (0..1), drop flag, FIFO of {pc, instr}.
REQ-017 o_IM_Req=1 iff no redirect this cycle, outstanding=0, and FIFO count below FIFO_DEPTH.
REQ-018 o_IM_Addr = fetch PC.
REQ-019 Grant (o_IM_Req & i_IM_Gnt): outstanding becomes 1, tagged PC is latched, fetch PC += 4 (wraps modulo 2^32).
REQ-020 Response (i_IM_RValid with outstanding=1 and drop=0): {tagged PC, i_IM_RData} is pushed and outstanding is cleared.
REQ-021 Response with drop=1: data is discarded, drop and outstanding are cleared, and no push occurs.
REQ-022 i_IM_RValid with outstanding=0 is ignored.
REQ-023 o_Valid = FIFO non-empty and not i_Redirect.
REQ-024 o_Instr/o_PC = FIFO head when o_Valid=1.
REQ-025 When o_Valid=0: o_Instr = 32'h0000_0013 (NOP) and o_PC = 0.
REQ-026 Pop when o_Valid=1 and i_Stall=0. With i_Stall=1 the head is held stable and nothing is popped.
REQ-027 Push and pop in the same cycle are allowed; count is unchanged.
REQ-028 Redirect takes priority over every other event in that cycle:
  - FIFO flushed;
  - fetch PC = {i_Redirect_PC[31:2], 2'b00};
  - no request issued that cycle;
  - a same-cycle response is discarded;
  - if outstanding=1 and no same-cycle response: drop is set and outstanding stays 1.
REQ-029 Redirect while drop is already set leaves drop set; at most one response is ever discarded.
REQ-030 Latency with zero-wait memory (Gnt in the request cycle, RValid the next cycle): o_Valid rises 2 cycles after the request cycle.
REQ-031 Steady-state throughput is one instruction per 2 cycles with single-outstanding memory. Higher throughput is out of scope.

Reset
REQ-032 While i_rstn=0, all outputs are forced asynchronously:
  - fetch PC = RESET_PC;
  - FIFO empty; outstanding and drop = 0;
  - o_IM_Req = 0, o_Valid = 0, o_Instr = NOP, o_PC = 0.
REQ-033 The first request (o_IM_Req=1, o_IM_Addr=RESET_PC) appears in the first clock edge cycle after i_rstn deasserts.
REQ-034 A reset asserted with a request outstanding abandons it; a stale i_IM_RValid after reset is ignored per REQ-022.

Structure
REQ-035 NOP encoding (32'h0000_0013) and the RESET_PC default live in the shared arvi package/defines and are shared with the decode stage.
REQ-036 The buffer is a separate sub-module fetch_fifo:
  - ports: push, pop, flush, data in/out, empty, full, count;
  - same clock and reset scheme;
  - flush has priority over push.
REQ-037 The top level holds only the request FSM (IDLE/WAIT_RSP), PC logic and drop logic.

Verification
REQ-038 Reset release, zero-wait memory, i_Stall=0 -> fetch addresses 0x0, 0x4, 0x8 in order; o_Valid first at cycle 2 with o_PC=0x0.
REQ-039 i_Stall=1 for 5 cycles with 2 entries buffered -> o_IM_Req=0 and o_Instr/o_PC stable; on release, both entries pop on consecutive cycles.
REQ-040 Redirect to 0x0000_0102 while a response is outstanding -> late response dropped; next request address 0x100; o_Valid=0 until the 0x100 data arrives.
REQ-041 Redirect in the same cycle as i_IM_RValid and a pop -> FIFO empty, o_Valid=0, o_Instr=NOP the next cycle.
REQ-042 Fetch PC at 0xFFFF_FFFC granted -> next request address 0x0000_0000.
REQ-043 Assert i_rstn=0 mid-WAIT_RSP, then release -> request at RESET_PC; a spurious RValid in the first cycle is ignored.
